// File: rtl/reg_file_wb.sv
// MIPS 32-entry register file on the write-back side: one staging register in front of
// the array, and two combinational read ports that see the staged write through a bypass.
module reg_file_wb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_dst,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic              pend_v,
   output logic [ADDR_W-1:0] pend_dst,
   output logic [CNT_W-1:0]  commit_cnt
);

   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] pend_data;
   logic              stage;

   // Writes to $0 are dropped here so they never reach the array or the counter.
   assign stage = wb_en && (wb_dst != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         pend_v     <= 1'b0;
         pend_dst   <= '0;
         pend_data  <= '0;
         commit_cnt <= '0;
      end else begin
         pend_v <= stage;
         if (stage) begin
            pend_dst  <= wb_dst;
            pend_data <= wb_data;
         end
         if (pend_v) begin
            regs[pend_dst] <= pend_data;
            if (commit_cnt != '1) commit_cnt <= commit_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      ra_data = regs[ra_addr];
      if (ra_addr == '0)                       ra_data = '0;
      else if (pend_v && ra_addr == pend_dst)  ra_data = pend_data;
   end

   always_comb begin
      rb_data = regs[rb_addr];
      if (rb_addr == '0)                       rb_data = '0;
      else if (pend_v && rb_addr == pend_dst)  rb_data = pend_data;
   end

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: the driver queues expected values for each cycle,
// the monitor pops and compares them at the falling edge.
module tb_reg_file_wb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_en;
   logic [4:0]  wb_dst;
   logic [31:0] wb_data;
   logic [4:0]  ra_addr, rb_addr;
   logic [31:0] ra_data, rb_data, ra_s, rb_s;
   logic        pend_v, pend_v_s;
   logic [4:0]  pend_dst, pend_dst_s;
   logic [15:0] commit_cnt;
   logic [3:0]  cnt_s;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   reg_file_wb dut (
      .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data),
      .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
      .pend_v(pend_v), .pend_dst(pend_dst), .commit_cnt(commit_cnt)
   );

   reg_file_wb #(.CNT_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data),
      .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_s), .rb_data(rb_s),
      .pend_v(pend_v_s), .pend_dst(pend_dst_s), .commit_cnt(cnt_s)
   );

   // sel: 0 ra, 1 rb, 2 pend_v, 3 pend_dst, 4 commit_cnt (16b), 5 commit_cnt (4b instance)
   task automatic chk(input string name, input int sel, input logic [31:0] e);
      exp_t x;
      x.name = name;
      x.sel  = sel;
      x.exp  = e;
      q.push_back(x);
   endtask

   task automatic chk_cnt(input string name, input int e);
      chk(name, 4, e);
      chk({name, "_sat"}, 5, (e > 15) ? 15 : e);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] e);
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, e);
   endtask

   always @(negedge clk) begin
      exp_t x;
      while (q.size() > 0) begin
         x = q.pop_front();
         case (x.sel)
            0: begin cmp(x.name, ra_data, x.exp); cmp({x.name, "_s"}, ra_s, x.exp); end
            1: begin cmp(x.name, rb_data, x.exp); cmp({x.name, "_s"}, rb_s, x.exp); end
            2: begin
               cmp(x.name, {31'h0, pend_v}, x.exp);
               cmp({x.name, "_s"}, {31'h0, pend_v_s}, x.exp);
            end
            3: begin
               cmp(x.name, {27'h0, pend_dst}, x.exp);
               cmp({x.name, "_s"}, {27'h0, pend_dst_s}, x.exp);
            end
            4: cmp(x.name, {16'h0, commit_cnt}, x.exp);
            default: cmp(x.name, {28'h0, cnt_s}, x.exp);
         endcase
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; wb_en = 1'b0; wb_dst = '0; wb_data = '0; ra_addr = '0; rb_addr = '0;
      cyc();
      // Reset: every index on both ports reads zero.
      for (int i = 0; i < 32; i++) begin
         ra_addr = 5'(i);
         rb_addr = 5'(31 - i);
         chk($sformatf("rst_ra%0d", i), 0, 32'h0);
         chk($sformatf("rst_rb%0d", 31 - i), 1, 32'h0);
         if (i == 0) begin
            chk("rst_pend_v", 2, 0);
            chk_cnt("rst_cnt", 0);
         end
         cyc();
      end
      rst_n = 1'b1;
      cyc();

      // Single write to 5: old value, then bypass, then array.
      wb_en = 1; wb_dst = 5; wb_data = 32'hDEADBEEF; ra_addr = 5; rb_addr = 0;
      chk("w5_present", 0, 32'h0);
      chk("w5_present_pv", 2, 0);
      cyc();
      wb_en = 0;
      chk("w5_bypass", 0, 32'hDEADBEEF);
      chk("w5_bypass_pv", 2, 1);
      chk("w5_bypass_pd", 3, 5);
      chk("w5_rb0", 1, 32'h0);
      chk_cnt("w5_bypass_cnt", 0);
      cyc();
      chk("w5_array", 0, 32'hDEADBEEF);
      chk("w5_array_pv", 2, 0);
      chk_cnt("w5_array_cnt", 1);
      cyc();

      // Write to $0 is dropped.
      wb_en = 1; wb_dst = 0; wb_data = 32'h12345678; ra_addr = 0; rb_addr = 5;
      chk("z_present", 0, 32'h0);
      cyc();
      wb_en = 0;
      chk("z_ra0", 0, 32'h0);
      chk("z_pv", 2, 0);
      chk("z_pd_hold", 3, 5);
      chk_cnt("z_cnt1", 1);
      cyc();
      chk("z_ra0b", 0, 32'h0);
      chk("z_rb5", 1, 32'hDEADBEEF);
      chk_cnt("z_cnt2", 1);
      cyc();

      // Link register stream on index 31.
      wb_en = 1; wb_dst = 31; wb_data = 32'h00400008; ra_addr = 31; rb_addr = 31;
      chk("l_present_ra", 0, 32'h0);
      chk("l_present_rb", 1, 32'h0);
      cyc();
      wb_data = 32'h1;
      chk("l0_ra", 0, 32'h00400008);
      chk("l0_rb", 1, 32'h00400008);
      chk_cnt("l0_cnt", 1);
      cyc();
      wb_data = 32'h2;
      chk("l1_ra", 0, 32'h1);
      chk("l1_rb", 1, 32'h1);
      chk_cnt("l1_cnt", 2);
      cyc();
      wb_data = 32'h3; rb_addr = 5;
      chk("l2_ra", 0, 32'h2);
      chk("l2_rb5", 1, 32'hDEADBEEF);
      chk_cnt("l2_cnt", 3);
      cyc();
      wb_en = 0; rb_addr = 31;
      chk("l3_ra", 0, 32'h3);
      chk("l3_rb", 1, 32'h3);
      chk("l3_pv", 2, 1);
      chk_cnt("l3_cnt", 4);
      cyc();
      chk("l_final_ra", 0, 32'h3);
      chk("l_final_pv", 2, 0);
      chk("l_final_pd", 3, 31);
      chk_cnt("l_final_cnt", 5);
      cyc();

      // Reset between staging and commit discards the staged write.
      wb_en = 1; wb_dst = 9; wb_data = 32'hCAFEF00D; ra_addr = 9; rb_addr = 31;
      chk("r_present", 0, 32'h0);
      cyc();
      wb_en = 0;
      chk("r_bypass", 0, 32'hCAFEF00D);
      chk("r_bypass_pv", 2, 1);
      chk_cnt("r_bypass_cnt", 5);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      cyc();
      chk("r_in_ra9", 0, 32'h0);
      chk("r_in_rb31", 1, 32'h0);
      chk("r_in_pv", 2, 0);
      chk("r_in_pd", 3, 0);
      chk_cnt("r_in_cnt", 0);
      cyc();
      rst_n = 1'b1;
      chk("r_out_ra9", 0, 32'h0);
      chk_cnt("r_out_cnt", 0);
      cyc();
      chk("r_after_ra9", 0, 32'h0);
      chk("r_after_pv", 2, 0);
      chk_cnt("r_after_cnt", 0);
      cyc();

      // Fresh write after reset.
      wb_en = 1; wb_dst = 7; wb_data = 32'h77; ra_addr = 7; rb_addr = 7;
      chk("p_present", 0, 32'h0);
      cyc();
      wb_en = 0;
      chk("p_bypass", 0, 32'h77);
      chk_cnt("p_bypass_cnt", 0);
      cyc();
      chk("p_array", 1, 32'h77);
      chk_cnt("p_array_cnt", 1);
      cyc();

      // 20 back-to-back writes to 8..27; 4-bit counter must pin at 0xF.
      for (int i = 0; i < 20; i++) begin
         wb_en = 1; wb_dst = 5'(i + 8); wb_data = 32'hA0000000 + 32'(i);
         rb_addr = 7;
         if (i == 0) begin
            ra_addr = 0;
            chk("s0_ra", 0, 32'h0);
         end else begin
            ra_addr = 5'(i + 7);
            chk($sformatf("s%0d_ra", i), 0, 32'hA0000000 + 32'(i - 1));
         end
         chk($sformatf("s%0d_rb7", i), 1, 32'h77);
         chk_cnt($sformatf("s%0d_cnt", i), 1 + ((i > 0) ? i - 1 : 0));
         cyc();
      end
      wb_en = 0; ra_addr = 27; rb_addr = 8;
      chk("s_tail_ra", 0, 32'hA0000013);
      chk("s_tail_rb", 1, 32'hA0000000);
      chk_cnt("s_tail_cnt", 20);
      cyc();
      chk("s_end_ra", 0, 32'hA0000013);
      chk("s_end_pv", 2, 0);
      chk_cnt("s_end_cnt", 21);
      cyc();
      @(negedge clk);
      #1;
      n_checks++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending, expected 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
